// File: rtl/tiny8_mem_bridge.sv
// Memory-side stage of the tiny8 core: turns held read/write strobes into a
// registered req/ack bus transaction with a wait-state timeout.
module tiny8_mem_bridge #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] mem_address,
  input  logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] mem_rdata,
  output logic             mem_resp,
  output logic             err,
  input  logic             err_clr,
  output logic             bus_req,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic             bus_ack,
  input  logic [WIDTH-1:0] bus_rdata
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      mem_rdata <= '0;
      mem_resp  <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      // A timeout later in this block overrides the clear, so set wins.
      if (err_clr)
        err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_write || mem_read) begin
            bus_addr  <= mem_address;
            bus_we    <= mem_write;
            bus_wdata <= mem_wdata;
            bus_req   <= 1'b1;
            count     <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req  <= 1'b0;
            mem_resp <= 1'b1;
            if (!bus_we)
              mem_rdata <= bus_rdata;
            state <= RESP;
          end else if (TIMEOUT > 0 && count == LAST) begin
            bus_req  <= 1'b0;
            mem_resp <= 1'b1;
            err      <= 1'b1;
            if (!bus_we)
              mem_rdata <= '1;
            state <= RESP;
          end else if (count != '1) begin
            count <= count + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny8_mem_bridge.sv
// Directed self-checking bench for tiny8_mem_bridge, built with TIMEOUT=4 so
// the abort path is reachable in a few cycles.
module tb_tiny8_mem_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_read = 1'b0;
  logic       mem_write = 1'b0;
  logic [7:0] mem_address = '0;
  logic [7:0] mem_wdata = '0;
  logic [7:0] mem_rdata;
  logic       mem_resp;
  logic       err;
  logic       err_clr = 1'b0;
  logic       bus_req;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_ack = 1'b0;
  logic [7:0] bus_rdata = '0;

  int num_checks = 0;
  int num_fails  = 0;

  tiny8_mem_bridge #(.WIDTH(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .err(err), .err_clr(err_clr),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance one rising edge, leaving us 1 time unit after it.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] resp_trace;

  initial begin
    applyStimulus(2);
    checkOutput("reset_bus_req", bus_req, 1'b0);
    checkOutput("reset_mem_resp", mem_resp, 1'b0);
    checkOutput("reset_err", err, 1'b0);
    checkOutput("reset_mem_rdata", mem_rdata, 8'h00);
    checkOutput("reset_bus_addr", bus_addr, 8'h00);
    rst = 1'b0;
    applyStimulus(1);

    // Zero-wait read
    mem_read = 1'b1; mem_address = 8'h3A;
    applyStimulus(1);
    checkOutput("t1_bus_req", bus_req, 1'b1);
    checkOutput("t1_bus_addr", bus_addr, 8'h3A);
    checkOutput("t1_bus_we", bus_we, 1'b0);
    checkOutput("t1_resp_early", mem_resp, 1'b0);
    mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 8'h5C;
    applyStimulus(1);
    checkOutput("t1_mem_resp", mem_resp, 1'b1);
    checkOutput("t1_mem_rdata", mem_rdata, 8'h5C);
    checkOutput("t1_bus_req_drop", bus_req, 1'b0);
    checkOutput("t1_err", err, 1'b0);
    bus_ack = 1'b0;
    applyStimulus(1);
    checkOutput("t1_resp_one_cycle", mem_resp, 1'b0);

    // Write with 3 wait states; datapath inputs change while in REQ
    mem_write = 1'b1; mem_address = 8'h10; mem_wdata = 8'hA5;
    applyStimulus(1);
    mem_write = 1'b0; mem_address = 8'hFF; mem_wdata = 8'h00;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_bus_req_%0d", i), bus_req, 1'b1);
      checkOutput($sformatf("t2_bus_addr_%0d", i), bus_addr, 8'h10);
      checkOutput($sformatf("t2_bus_wdata_%0d", i), bus_wdata, 8'hA5);
      checkOutput($sformatf("t2_bus_we_%0d", i), bus_we, 1'b1);
      checkOutput($sformatf("t2_no_resp_%0d", i), mem_resp, 1'b0);
      if (i == 3) bus_ack = 1'b1;
      applyStimulus(1);
    end
    checkOutput("t2_mem_resp", mem_resp, 1'b1);
    checkOutput("t2_rdata_kept", mem_rdata, 8'h5C);
    bus_ack = 1'b0;
    applyStimulus(1);
    checkOutput("t2_resp_one_cycle", mem_resp, 1'b0);

    // Timeout on a read with no ack
    mem_read = 1'b1; mem_address = 8'h40;
    applyStimulus(1);
    mem_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t3_bus_req_%0d", i), bus_req, 1'b1);
      checkOutput($sformatf("t3_no_resp_%0d", i), mem_resp, 1'b0);
      applyStimulus(1);
    end
    checkOutput("t3_bus_req_drop", bus_req, 1'b0);
    checkOutput("t3_mem_resp", mem_resp, 1'b1);
    checkOutput("t3_rdata_ff", mem_rdata, 8'hFF);
    checkOutput("t3_err_set", err, 1'b1);
    applyStimulus(1);
    mem_read = 1'b1; mem_address = 8'h41;
    applyStimulus(1);
    mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 8'h33;
    applyStimulus(1);
    bus_ack = 1'b0;
    checkOutput("t3_good_resp", mem_resp, 1'b1);
    checkOutput("t3_good_rdata", mem_rdata, 8'h33);
    checkOutput("t3_err_sticky", err, 1'b1);
    applyStimulus(1);
    err_clr = 1'b1;
    applyStimulus(1);
    err_clr = 1'b0;
    checkOutput("t3_err_cleared", err, 1'b0);

    // Both strobes: write wins, single transaction
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 8'h22; mem_wdata = 8'h07;
    applyStimulus(1);
    mem_read = 1'b0; mem_write = 1'b0;
    checkOutput("t4_bus_we", bus_we, 1'b1);
    checkOutput("t4_bus_wdata", bus_wdata, 8'h07);
    checkOutput("t4_bus_addr", bus_addr, 8'h22);
    bus_ack = 1'b1;
    applyStimulus(1);
    bus_ack = 1'b0;
    checkOutput("t4_mem_resp", mem_resp, 1'b1);
    checkOutput("t4_rdata_kept", mem_rdata, 8'h33);
    applyStimulus(2);
    checkOutput("t4_single_txn_req", bus_req, 1'b0);
    checkOutput("t4_single_txn_resp", mem_resp, 1'b0);

    // Asynchronous reset in the middle of a stalled REQ
    mem_read = 1'b1; mem_address = 8'h55;
    applyStimulus(1);
    mem_read = 1'b0;
    applyStimulus(2);
    checkOutput("t5_in_req", bus_req, 1'b1);
    #3 rst = 1'b1;
    #1;
    checkOutput("t5_async_bus_req", bus_req, 1'b0);
    checkOutput("t5_async_bus_addr", bus_addr, 8'h00);
    checkOutput("t5_async_bus_we", bus_we, 1'b0);
    checkOutput("t5_async_rdata", mem_rdata, 8'h00);
    checkOutput("t5_async_resp", mem_resp, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus_ack = 1'b1;
    applyStimulus(2);
    checkOutput("t5_ack_ignored_req", bus_req, 1'b0);
    checkOutput("t5_ack_ignored_resp", mem_resp, 1'b0);
    bus_ack = 1'b0;

    // Spurious ack in IDLE, then back-to-back reads with a held strobe
    bus_ack = 1'b1;
    applyStimulus(1);
    checkOutput("t6_spurious_resp", mem_resp, 1'b0);
    checkOutput("t6_spurious_req", bus_req, 1'b0);
    mem_read = 1'b1; mem_address = 8'h60; bus_rdata = 8'h77;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      resp_trace[i] = mem_resp;
      if (i == 4) mem_read = 1'b0;
    end
    bus_ack = 1'b0;
    checkOutput("t6_resp_pattern", resp_trace, 6'b010010);
    checkOutput("t6_rdata", mem_rdata, 8'h77);
    applyStimulus(1);
    checkOutput("t6_no_third_txn", bus_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/tiny8_mem_bridge.md
Name: tiny8_mem_bridge

Overview:
Memory-side stage directly downstream of the tiny8 datapath. It takes the datapath's combinational address and write-data outputs, together with read/write strobes from the control unit, and runs a req/ack transaction on the external memory bus. It returns registered read data and a one-cycle completion pulse. A wait-state timeout prevents a dead slave from hanging the core.

Parameters:
WIDTH, 8, data and address width (matches tiny8_word).
TIMEOUT, 16, maximum REQ cycles without bus_ack before abort; 0 disables the timeout.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
mem_read  input  1  control requests a read; held until mem_resp
mem_write  input  1  control requests a write; held until mem_resp
mem_address  input  WIDTH  address from datapath
mem_wdata  input  WIDTH  write data from datapath
mem_rdata  output  WIDTH  registered read data, valid when mem_resp=1
mem_resp  output  1  one-cycle transaction-complete pulse
err  output  1  sticky timeout flag
err_clr  input  1  synchronous clear of err
bus_req  output  1  bus request, registered
bus_we  output  1  1=write, 0=read, registered
bus_addr  output  WIDTH  registered bus address
bus_wdata  output  WIDTH  registered bus write data
bus_ack  input  1  slave completion, sampled only in REQ
bus_rdata  input  WIDTH  slave read data, sampled with bus_ack

Behaviour:
- Reset (async, rst=1): state=IDLE. bus_req, bus_we, bus_addr, bus_wdata, mem_rdata, mem_resp, err and the wait counter all go to 0. Any in-flight transaction is aborted and bus_req drops immediately.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If mem_write=1 or mem_read=1, capture the request on the next edge: bus_addr<=mem_address, bus_we<=mem_write, bus_wdata<=mem_wdata (written even for reads; don't-care), bus_req<=1, counter<=0, go to REQ.
  - Both strobes asserted: write wins (bus_we=1). No error.
  - Otherwise stay in IDLE with bus_req=0.
- REQ:
  - bus_req=1. bus_addr, bus_we and bus_wdata are held stable. Changes on mem_* inputs are ignored.
  - bus_ack=1: bus_req<=0. For a read, mem_rdata<=bus_rdata; for a write, mem_rdata is unchanged. mem_resp<=1, go to RESP.
  - bus_ack=0 with TIMEOUT>0 and counter==TIMEOUT-1: abort. bus_req<=0, err<=1, mem_resp<=1, go to RESP. A read returns mem_rdata<=all ones (8'hFF for WIDTH=8); a write leaves mem_rdata unchanged.
  - Otherwise counter<=counter+1 and stay in REQ. Counter width is clog2(TIMEOUT+1), minimum 1. The counter never wraps.
- RESP:
  - mem_resp=1 for exactly one cycle, then unconditionally return to IDLE with mem_resp<=0.
  - Strobes are ignored in RESP. A strobe still high in the following IDLE cycle starts a new transaction, so control must drop its strobe on the cycle it sees mem_resp unless it wants a back-to-back access.
- Latency: strobe sampled at edge N puts bus_req=1 in cycle N+1. An ack in cycle N+1 gives mem_resp=1 in cycle N+2. A zero-wait access therefore takes 2 cycles strobe-to-resp; each wait cycle adds 1.
- Back-to-back throughput: one access per 3 cycles (IDLE, REQ, RESP) with zero-wait slaves.
- bus_ack seen in IDLE or RESP is ignored and has no side effects.
- err:
  - Set on timeout, cleared by err_clr in any state.
  - Timeout and err_clr in the same cycle: set wins, err=1.
  - err does not block further transactions.
- mem_rdata holds its value between transactions.
- No combinational path from any input to any output; all outputs are flops.

Test Plan:
1. Zero-wait read: mem_read=1, mem_address=8'h3A; slave acks in the first REQ cycle with bus_rdata=8'h5C -> bus_req=1 for 1 cycle with bus_addr=8'h3A and bus_we=0; mem_resp=1 two cycles after the strobe with mem_rdata=8'h5C; err=0.
2. Write with 3 wait states: mem_write=1, addr=8'h10, wdata=8'hA5; ack on the 4th REQ cycle -> bus_req held 4 cycles with stable bus_addr=8'h10, bus_wdata=8'hA5, bus_we=1; mem_resp pulses once, 5 cycles after the strobe; mem_rdata unchanged.
3. Timeout: TIMEOUT=4, read with no ack -> bus_req high exactly 4 cycles, then mem_resp=1 with mem_rdata=8'hFF and err=1. err stays 1 across a following good read until err_clr=1, then reads 0.
4. Simultaneous strobes: mem_read=mem_write=1, addr=8'h22, wdata=8'h07 -> bus_we=1 with bus_wdata=8'h07; exactly one transaction.
5. Reset mid-REQ: assert rst asynchronously (between edges) during the 2nd wait cycle -> bus_req falls without waiting for an edge; all outputs 0; after release, bus_ack=1 is ignored and the FSM stays in IDLE.
6. Spurious ack plus back-to-back: pulse bus_ack in IDLE -> no mem_resp. Then hold mem_read high across two zero-wait accesses -> mem_resp pulses exactly 3 cycles apart.
